// File: rtl/pulse_monitor_if.sv
// Pulse monitor bus: raw pulse input, control strobes and measured statistics.
`timescale 1ns/1ps
interface pulse_monitor_if #(
  parameter int CNT_W = 16
);
  logic             signal_in;
  logic             enable;
  logic             clear_stats;
  logic             event_pulse;
  logic [CNT_W-1:0] pulse_count;
  logic [CNT_W-1:0] last_period;
  logic             period_valid;
  logic             overflow;
  logic             timeout;
  logic [1:0]       state;

  modport master (
    output signal_in, enable, clear_stats,
    input  event_pulse, pulse_count, last_period, period_valid, overflow, timeout, state
  );

  modport slave (
    input  signal_in, enable, clear_stats,
    output event_pulse, pulse_count, last_period, period_valid, overflow, timeout, state
  );
endinterface

// File: rtl/pulse_monitor.sv
// Captures narrow asynchronous pulses, synchronizes them into the clock domain,
// counts them and measures the spacing between consecutive pulses in cycles.
`timescale 1ns/1ps
module pulse_monitor #(
  parameter int CNT_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_INTERVAL = 1000
) (
  input  logic            clock,
  input  logic            reset_n,
  pulse_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX        = '1;
  localparam logic [CNT_W-1:0] INTERVAL_LIMIT = CNT_W'(MAX_INTERVAL);

  logic                   signal_in;
  logic                   catch_q;
  logic                   catch_clr_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   event_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       interval_q;
  logic                   period_valid_q;
  logic                   overflow_q;
  logic                   timeout_q;

  assign signal_in   = bus.signal_in;
  assign catch_clr_n = reset_n & ~sync_q[SYNC_STAGES-1];

  // Catch flop holds a pulse of any width until the synchronized copy acknowledges it.
  always_ff @(posedge signal_in or negedge catch_clr_n) begin
    if (!catch_clr_n) catch_q <= 1'b0;
    else              catch_q <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], catch_q};
      last_q  <= sync_q[SYNC_STAGES-1];
      event_q <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

  // clear_stats outranks enable, and both outrank any event seen in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      period_q       <= '0;
      interval_q     <= '0;
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (bus.clear_stats) begin
        count_q    <= '0;
        period_q   <= '0;
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
        interval_q <= '0;
        state_q    <= bus.enable ? ARMED : IDLE;
      end else if (!bus.enable) begin
        state_q    <= IDLE;
        interval_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (event_q) begin
              if (count_q == CNT_MAX) overflow_q <= 1'b1;
              else                    count_q    <= count_q + 1'b1;
              interval_q <= CNT_W'(1);
              state_q    <= MEASURE;
            end
          end
          MEASURE: begin
            if (event_q) begin
              period_q       <= interval_q;
              period_valid_q <= 1'b1;
              if (count_q == CNT_MAX) overflow_q <= 1'b1;
              else                    count_q    <= count_q + 1'b1;
              interval_q <= CNT_W'(1);
            end else if (interval_q >= INTERVAL_LIMIT) begin
              timeout_q  <= 1'b1;
              interval_q <= '0;
              state_q    <= ARMED;
            end else begin
              interval_q <= interval_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.event_pulse  = event_q;
  assign bus.pulse_count  = count_q;
  assign bus.last_period  = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.timeout      = timeout_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor: a default instance and a 4-bit counter
// instance, 12-unit clock, 3-unit pulses launched on the falling clock edge.
`timescale 1ns/1ps
module tb_pulse_monitor;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  pulse_monitor_if #(.CNT_W(16)) big_if ();
  pulse_monitor_if #(.CNT_W(4))  small_if ();

  pulse_monitor #(.CNT_W(16), .SYNC_STAGES(2), .MAX_INTERVAL(1000)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (big_if.slave)
  );

  pulse_monitor #(.CNT_W(4), .SYNC_STAGES(2), .MAX_INTERVAL(12)) dut_small (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (small_if.slave)
  );

  initial begin
    clock = 1'b0;
    forever #6 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_dut();
    reset_n              = 1'b0;
    big_if.signal_in     = 1'b0;
    big_if.enable        = 1'b0;
    big_if.clear_stats   = 1'b0;
    small_if.signal_in   = 1'b0;
    small_if.enable      = 1'b0;
    small_if.clear_stats = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n              = 1'b0;
    big_if.signal_in     = 1'b0;
    big_if.enable        = 1'b1;
    big_if.clear_stats   = 1'b0;
    small_if.signal_in   = 1'b0;
    small_if.enable      = 1'b1;
    small_if.clear_stats = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({big_if.event_pulse, big_if.period_valid, big_if.overflow, big_if.timeout} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {big_if.event_pulse, big_if.period_valid, big_if.overflow, big_if.timeout});
    end
    vectors++;
    if (big_if.pulse_count !== 16'd0 || big_if.last_period !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stats: got count %0d period %0d expected 0 0",
               big_if.pulse_count, big_if.last_period);
    end
    vectors++;
    if (big_if.state !== 2'd0 || small_if.state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %0d/%0d expected 0/0", big_if.state, small_if.state);
    end
  endtask

  task automatic test_single_pulse();
    reset_dut();
    big_if.enable = 1'b1;
    repeat (2) @(negedge clock);
    big_if.signal_in = 1'b1;
    #3 big_if.signal_in = 1'b0;
    // Rise on a falling edge: event_pulse is visible on the third falling edge after it.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      vectors++;
      if (big_if.event_pulse !== (k == 3)) begin
        miscompares++;
        $display("[TB] FAIL single_event_k%0d: got %b expected %b", k, big_if.event_pulse, (k == 3));
      end
    end
    vectors++;
    if (big_if.pulse_count !== 16'd1 || big_if.state !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL single_result: got count %0d state %0d expected 1 2",
               big_if.pulse_count, big_if.state);
    end
  endtask

  task automatic test_periodic();
    int pv_seen;
    int ev_seen;
    pv_seen = 0;
    ev_seen = 0;
    reset_dut();
    big_if.enable = 1'b1;
    repeat (2) @(negedge clock);
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clock);
      if (big_if.period_valid === 1'b1) begin
        pv_seen++;
        vectors++;
        if (big_if.last_period !== 16'd8) begin
          miscompares++;
          $display("[TB] FAIL periodic_period: got %0d expected 8", big_if.last_period);
        end
      end
      if (cyc % 8 == 0 && cyc < 40) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (pv_seen != 4) begin
      miscompares++;
      $display("[TB] FAIL periodic_valid_count: got %0d expected 4", pv_seen);
    end
    vectors++;
    if (big_if.pulse_count !== 16'd5 || big_if.timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL periodic_result: got count %0d timeout %b expected 5 0",
               big_if.pulse_count, big_if.timeout);
    end
    // With enable low the pulse still strobes event_pulse but statistics hold.
    big_if.enable = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      if (big_if.event_pulse === 1'b1) ev_seen++;
      if (cyc == 0) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (ev_seen != 1 || big_if.pulse_count !== 16'd5 || big_if.state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL disabled_hold: got events %0d count %0d state %0d expected 1 5 0",
               ev_seen, big_if.pulse_count, big_if.state);
    end
  endtask

  task automatic test_timeout();
    int pv_seen;
    pv_seen = 0;
    reset_dut();
    big_if.enable = 1'b1;
    repeat (2) @(negedge clock);
    @(negedge clock);
    big_if.signal_in = 1'b1;
    #3 big_if.signal_in = 1'b0;
    repeat (1003) @(negedge clock);
    vectors++;
    if (big_if.timeout !== 1'b0 || big_if.state !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: got timeout %b state %0d expected 0 2",
               big_if.timeout, big_if.state);
    end
    @(negedge clock);
    vectors++;
    if (big_if.timeout !== 1'b1 || big_if.state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL timeout_fire: got timeout %b state %0d expected 1 1",
               big_if.timeout, big_if.state);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      if (big_if.period_valid === 1'b1) pv_seen++;
      if (cyc == 0) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (pv_seen != 0 || big_if.pulse_count !== 16'd2 || big_if.timeout !== 1'b1 || big_if.state !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL timeout_next: got pv %0d count %0d timeout %b state %0d expected 0 2 1 2",
               pv_seen, big_if.pulse_count, big_if.timeout, big_if.state);
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    small_if.enable = 1'b1;
    repeat (2) @(negedge clock);
    for (int cyc = 0; cyc < 142; cyc++) begin
      @(negedge clock);
      if (cyc == 119) begin
        vectors++;
        if (small_if.pulse_count !== 4'd15 || small_if.overflow !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL sat_at_max: got count %0d overflow %b expected 15 0",
                   small_if.pulse_count, small_if.overflow);
        end
      end
      if (cyc % 8 == 0 && cyc < 136) begin
        small_if.signal_in = 1'b1;
        #3 small_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (small_if.pulse_count !== 4'd15 || small_if.overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_final: got count %0d overflow %b expected 15 1",
               small_if.pulse_count, small_if.overflow);
    end
    vectors++;
    if (small_if.last_period !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL sat_period: got %0d expected 8", small_if.last_period);
    end
  endtask

  task automatic test_clear_collision();
    int pv_seen;
    pv_seen = 0;
    reset_dut();
    big_if.enable = 1'b1;
    repeat (2) @(negedge clock);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clock);
      if (cyc == 0 || cyc == 8) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (big_if.pulse_count !== 16'd2 || big_if.last_period !== 16'd8) begin
      miscompares++;
      $display("[TB] FAIL clear_setup: got count %0d period %0d expected 2 8",
               big_if.pulse_count, big_if.last_period);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
      if (cyc == 3) begin
        vectors++;
        if (big_if.event_pulse !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL clear_event_present: got %b expected 1", big_if.event_pulse);
        end
        big_if.clear_stats = 1'b1;
      end
      if (cyc == 4) big_if.clear_stats = 1'b0;
    end
    vectors++;
    if (big_if.pulse_count !== 16'd0 || big_if.last_period !== 16'd0 || big_if.state !== 2'd1
        || big_if.period_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_result: got count %0d period %0d state %0d pv %b expected 0 0 1 0",
               big_if.pulse_count, big_if.last_period, big_if.state, big_if.period_valid);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      if (big_if.period_valid === 1'b1) pv_seen++;
      if (cyc == 0) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (big_if.pulse_count !== 16'd1 || big_if.state !== 2'd2 || pv_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL clear_next: got count %0d state %0d pv %0d expected 1 2 0",
               big_if.pulse_count, big_if.state, pv_seen);
    end
  endtask

  task automatic test_reset_mid();
    int ev_seen;
    ev_seen = 0;
    reset_dut();
    big_if.enable = 1'b1;
    repeat (2) @(negedge clock);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        big_if.signal_in = 1'b1;
        #3 big_if.signal_in = 1'b0;
      end
    end
    vectors++;
    if (big_if.state !== 2'd2 || big_if.pulse_count !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL midreset_setup: got state %0d count %0d expected 2 1",
               big_if.state, big_if.pulse_count);
    end
    // A fresh pulse sets the catch flop, then reset lands while it is still high.
    @(negedge clock);
    big_if.signal_in = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({big_if.event_pulse, big_if.period_valid, big_if.overflow, big_if.timeout} !== 4'b0000
        || big_if.pulse_count !== 16'd0 || big_if.last_period !== 16'd0 || big_if.state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear: got flags %b count %0d period %0d state %0d expected 0000 0 0 0",
               {big_if.event_pulse, big_if.period_valid, big_if.overflow, big_if.timeout},
               big_if.pulse_count, big_if.last_period, big_if.state);
    end
    #1;
    reset_n          = 1'b1;
    big_if.signal_in = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clock);
      if (big_if.event_pulse === 1'b1) ev_seen++;
    end
    vectors++;
    if (ev_seen != 0 || big_if.pulse_count !== 16'd0 || big_if.state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL midreset_after: got events %0d count %0d state %0d expected 0 0 1",
               ev_seen, big_if.pulse_count, big_if.state);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    test_reset();
    test_single_pulse();
    test_periodic();
    test_timeout();
    test_saturation();
    test_clear_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
